// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations and immediate formats.
package core_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_e;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  // alt selects SUB/SRA; callers pass 0 where the alternate form does not exist.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the RV32I instruction formats.
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] inst_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  logic unused_opcode;
  assign unused_opcode = ^inst_i[6:0];

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      ImmI:    imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      ImmS:    imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      ImmB:    imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      ImmU:    imm_o = {inst_i[31:12], 12'b0};
      ImmJ:    imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: control decode, destination scoreboard for RAW stalls, output register.
module decode
  import core_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic        conflict_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output alu_op_e     alu_op_o,
  output logic [2:0]  funct3_o,
  output logic        reg_we_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        alu_src_imm_o,
  output logic        illegal_o
);

  logic [4:0] slot_q [SB_DEPTH];

  logic       bubble, valid_d, reg_we_d, mem_re_d, mem_we_d, branch_d, jump_d;
  logic       alu_src_imm_d, illegal_d, uses_rs1, uses_rs2, rs1_hit, rs2_hit;
  alu_op_e    alu_op_d;
  imm_fmt_e   fmt;
  logic [31:0] imm_d;
  logic [4:0]  rd_d;
  logic [2:0]  funct3_d;

  assign bubble     = (inst_i == '0);
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  always_comb begin
    valid_d       = 1'b1;
    reg_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    branch_d      = 1'b0;
    jump_d        = 1'b0;
    alu_src_imm_d = 1'b0;
    illegal_d     = 1'b0;
    alu_op_d      = AluAdd;
    fmt           = ImmNone;
    uses_rs1      = 1'b1;
    uses_rs2      = 1'b0;
    case (inst_i[6:0])
      OpcOp: begin
        if (inst_i[31:25] == 7'h00 || inst_i[31:25] == 7'h20) begin
          reg_we_d = 1'b1;
          uses_rs2 = 1'b1;
          alu_op_d = alu_from_funct3(inst_i[14:12], inst_i[30]);
        end else begin
          illegal_d = 1'b1;
        end
      end
      OpcOpImm: begin
        reg_we_d      = 1'b1;
        alu_src_imm_d = 1'b1;
        fmt           = ImmI;
        // Only shifts have an alternate immediate form; addi has no subi.
        alu_op_d      = alu_from_funct3(inst_i[14:12], inst_i[14:12] == 3'b101 && inst_i[30]);
      end
      OpcLoad: begin
        reg_we_d      = 1'b1;
        mem_re_d      = 1'b1;
        alu_src_imm_d = 1'b1;
        fmt           = ImmI;
      end
      OpcStore: begin
        mem_we_d      = 1'b1;
        alu_src_imm_d = 1'b1;
        uses_rs2      = 1'b1;
        fmt           = ImmS;
      end
      OpcBranch: begin
        branch_d = 1'b1;
        uses_rs2 = 1'b1;
        alu_op_d = AluSub;
        fmt      = ImmB;
      end
      OpcJal: begin
        reg_we_d = 1'b1;
        jump_d   = 1'b1;
        uses_rs1 = 1'b0;
        fmt      = ImmJ;
      end
      OpcJalr: begin
        reg_we_d      = 1'b1;
        jump_d        = 1'b1;
        alu_src_imm_d = 1'b1;
        fmt           = ImmI;
      end
      OpcLui: begin
        reg_we_d      = 1'b1;
        alu_src_imm_d = 1'b1;
        uses_rs1      = 1'b0;
        alu_op_d      = AluPassB;
        fmt           = ImmU;
      end
      OpcAuipc: begin
        reg_we_d      = 1'b1;
        alu_src_imm_d = 1'b1;
        uses_rs1      = 1'b0;
        fmt           = ImmU;
      end
      default: illegal_d = 1'b1;
    endcase
    if (bubble) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      uses_rs1  = 1'b0;
    end
  end

  imm_gen u_imm_gen (
    .inst_i (inst_i),
    .fmt_i  (fmt),
    .imm_o  (imm_d)
  );

  assign rd_d     = reg_we_d ? inst_i[11:7] : 5'd0;
  assign funct3_d = (valid_d && !illegal_d) ? inst_i[14:12] : 3'd0;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      if (slot_q[k] == rs1_addr_o) rs1_hit = 1'b1;
      if (slot_q[k] == rs2_addr_o) rs2_hit = 1'b1;
    end
  end

  assign conflict_o = !flush_i && !bubble &&
                      ((uses_rs1 && rs1_addr_o != 5'd0 && rs1_hit) ||
                       (uses_rs2 && rs2_addr_o != 5'd0 && rs2_hit));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < SB_DEPTH; k++) slot_q[k] <= '0;
      valid_o       <= 1'b0;
      pc_o          <= '0;
      rd_o          <= '0;
      imm_o         <= '0;
      alu_op_o      <= AluAdd;
      funct3_o      <= '0;
      reg_we_o      <= 1'b0;
      mem_re_o      <= 1'b0;
      mem_we_o      <= 1'b0;
      branch_o      <= 1'b0;
      jump_o        <= 1'b0;
      alu_src_imm_o <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      // Older slots drain every cycle so a stall clears within SB_DEPTH cycles.
      for (int unsigned k = 1; k < SB_DEPTH; k++) slot_q[k] <= slot_q[k-1];
      if (flush_i || conflict_o) begin
        slot_q[0]     <= '0;
        valid_o       <= 1'b0;
        pc_o          <= '0;
        rd_o          <= '0;
        imm_o         <= '0;
        alu_op_o      <= AluAdd;
        funct3_o      <= '0;
        reg_we_o      <= 1'b0;
        mem_re_o      <= 1'b0;
        mem_we_o      <= 1'b0;
        branch_o      <= 1'b0;
        jump_o        <= 1'b0;
        alu_src_imm_o <= 1'b0;
        illegal_o     <= 1'b0;
      end else begin
        slot_q[0]     <= rd_d;
        valid_o       <= valid_d;
        pc_o          <= valid_d ? pc_i : '0;
        rd_o          <= rd_d;
        imm_o         <= imm_d;
        alu_op_o      <= alu_op_d;
        funct3_o      <= funct3_d;
        reg_we_o      <= reg_we_d;
        mem_re_o      <= mem_re_d;
        mem_we_o      <= mem_we_d;
        branch_o      <= branch_d;
        jump_o        <= jump_d;
        alu_src_imm_o <= alu_src_imm_d;
        illegal_o     <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: vector table plus stall, flush and reset sequences.
module tb_decode;
  import core_pkg::*;

  localparam int unsigned SbDepth = 3;
  localparam logic [6:0] FWe = 7'b1000000, FRe = 7'b0100000, FMw = 7'b0010000,
                         FBr = 7'b0001000, FJp = 7'b0000100, FImm = 7'b0000010,
                         FIll = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, pc;
  logic        flush;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic        conflict, valid, reg_we, mem_re, mem_we, branch, jump, alu_src_imm, illegal;
  logic [31:0] pc_q, imm;
  alu_op_e     alu_op;
  logic [2:0]  funct3;
  logic [6:0]  flags;

  assign flags = {reg_we, mem_re, mem_we, branch, jump, alu_src_imm, illegal};

  decode #(.SB_DEPTH(SbDepth)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .inst_i        (inst),
    .pc_i          (pc),
    .flush_i       (flush),
    .rs1_addr_o    (rs1_addr),
    .rs2_addr_o    (rs2_addr),
    .conflict_o    (conflict),
    .valid_o       (valid),
    .pc_o          (pc_q),
    .rd_o          (rd),
    .imm_o         (imm),
    .alu_op_o      (alu_op),
    .funct3_o      (funct3),
    .reg_we_o      (reg_we),
    .mem_re_o      (mem_re),
    .mem_we_o      (mem_we),
    .branch_o      (branch),
    .jump_o        (jump),
    .alu_src_imm_o (alu_src_imm),
    .illegal_o     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu;
    logic [6:0]  flags;
    logic [2:0]  f3;
  } vec_t;

  vec_t vecs [15];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    inst  = '0;
    flush = 1'b0;
    repeat (SbDepth) tick();
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 5'd0, 5'd5, 1'b1, 5'd1, 32'h5, AluAdd, FWe | FImm, 3'd0};
    vecs[1]  = '{32'hFE000EE3, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFC, AluSub, FBr, 3'd0};
    vecs[2]  = '{32'h001000EF, 5'd0, 5'd1, 1'b1, 5'd1, 32'h800, AluAdd, FWe | FJp, 3'd0};
    vecs[3]  = '{32'hFE002FA3, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, AluAdd, FMw | FImm, 3'd2};
    vecs[4]  = '{32'h00108133, 5'd1, 5'd1, 1'b1, 5'd2, 32'h0, AluAdd, FWe, 3'd0};
    vecs[5]  = '{32'h402081B3, 5'd1, 5'd2, 1'b1, 5'd3, 32'h0, AluSub, FWe, 3'd0};
    vecs[6]  = '{32'h123451B7, 5'd8, 5'd3, 1'b1, 5'd3, 32'h12345000, AluPassB, FWe | FImm, 3'd5};
    vecs[7]  = '{32'h00812283, 5'd2, 5'd8, 1'b1, 5'd5, 32'h8, AluAdd, FWe | FRe | FImm, 3'd2};
    vecs[8]  = '{32'h0000007F, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, AluAdd, FIll, 3'd0};
    vecs[9]  = '{32'h023100B3, 5'd2, 5'd3, 1'b1, 5'd0, 32'h0, AluAdd, FIll, 3'd0};
    vecs[10] = '{32'h40325213, 5'd4, 5'd3, 1'b1, 5'd4, 32'h403, AluSra, FWe | FImm, 3'd5};
    vecs[11] = '{32'h00001317, 5'd0, 5'd0, 1'b1, 5'd6, 32'h1000, AluAdd, FWe | FImm, 3'd1};
    vecs[12] = '{32'h00000000, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, AluAdd, 7'd0, 3'd0};
    vecs[13] = '{32'h00000013, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, AluAdd, FWe | FImm, 3'd0};
    vecs[14] = '{32'h004280E7, 5'd5, 5'd4, 1'b1, 5'd1, 32'h4, AluAdd, FWe | FJp | FImm, 3'd0};

    rst_n = 1'b0;
    inst  = '0;
    pc    = '0;
    flush = 1'b0;
    #12;
    check("reset valid", 32'(valid), 32'd0);
    check("reset rd", 32'(rd), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset conflict", 32'(conflict), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      inst = vecs[i].inst;
      pc   = 32'h100 + 32'(i) * 4;
      #1;
      check($sformatf("v%0d conflict", i), 32'(conflict), 32'd0);
      check($sformatf("v%0d rs1", i), 32'(rs1_addr), 32'(vecs[i].rs1));
      check($sformatf("v%0d rs2", i), 32'(rs2_addr), 32'(vecs[i].rs2));
      tick();
      check($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
      check($sformatf("v%0d pc", i), pc_q, vecs[i].valid ? 32'h100 + 32'(i) * 4 : 32'h0);
      check($sformatf("v%0d rd", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d imm", i), imm, vecs[i].imm);
      check($sformatf("v%0d alu", i), 32'(alu_op), 32'(vecs[i].alu));
      check($sformatf("v%0d flags", i), 32'(flags), 32'(vecs[i].flags));
      check($sformatf("v%0d funct3", i), 32'(funct3), 32'(vecs[i].f3));
      drain();
    end

    // RAW: addi x1,x0,1 then add x2,x1,x1 stalls SbDepth cycles
    inst = 32'h00100093;
    tick();
    inst = 32'h00108133;
    for (int c = 0; c < int'(SbDepth); c++) begin
      #1;
      check($sformatf("raw conflict c%0d", c), 32'(conflict), 32'd1);
      tick();
      check($sformatf("raw bubble c%0d", c), 32'(valid), 32'd0);
    end
    #1;
    check("raw release", 32'(conflict), 32'd0);
    tick();
    check("raw issue valid", 32'(valid), 32'd1);
    check("raw issue rd", 32'(rd), 32'd2);
    check("raw issue alu", 32'(alu_op), 32'(AluAdd));
    drain();

    // x0 destination and non-use of rs1
    inst = 32'h00000013;
    tick();
    inst = 32'h00002023;
    #1;
    check("x0 no conflict", 32'(conflict), 32'd0);
    drain();
    inst = 32'h123451B7;
    tick();
    #1;
    check("lui lui no conflict", 32'(conflict), 32'd0);
    inst = 32'h00302023;
    #1;
    check("store rs2 conflict", 32'(conflict), 32'd1);
    drain();

    // Same-register read/write does not self-conflict
    inst = 32'h00108093;
    #1;
    check("self no conflict", 32'(conflict), 32'd0);
    drain();

    // Flush beats conflict
    inst = 32'h00100093;
    tick();
    inst  = 32'h00108133;
    flush = 1'b1;
    #1;
    check("flush conflict", 32'(conflict), 32'd0);
    tick();
    check("flush valid", 32'(valid), 32'd0);
    drain();
    // Flushed addi x7 must not enter the scoreboard
    inst  = 32'h00100393;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    inst  = 32'h00738433;
    #1;
    check("flush slot0 clear", 32'(conflict), 32'd0);
    tick();
    check("post flush rd", 32'(rd), 32'd8);
    drain();

    // Illegal with nonzero rd field records no destination
    inst = 32'h000000FF;
    tick();
    check("illegal flag", 32'(illegal), 32'd1);
    check("illegal valid", 32'(valid), 32'd1);
    check("illegal reg_we", 32'(reg_we), 32'd0);
    check("illegal rd", 32'(rd), 32'd0);
    inst = 32'h00108133;
    #1;
    check("illegal no entry", 32'(conflict), 32'd0);
    drain();

    // Reset mid-stall drops conflict immediately
    inst = 32'h00100093;
    tick();
    inst = 32'h00108133;
    #1;
    check("pre-reset conflict", 32'(conflict), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset conflict", 32'(conflict), 32'd0);
    check("mid reset valid", 32'(valid), 32'd0);
    check("mid reset rd", 32'(rd), 32'd0);
    inst = 32'h00500093;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post reset valid", 32'(valid), 32'd1);
    check("post reset rd", 32'(rd), 32'd1);
    check("post reset imm", imm, 32'd5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the RV32I core. It consumes the 32-bit instruction word registered by the fetch stage and decodes it into register addresses, a sign-extended immediate and control fields. It tracks the destination registers of in-flight instructions in a small scoreboard and raises a stall (`conflict_o`) back to fetch on read-after-write hazards. Decoded results go into one output register that feeds execute.

## Interface
Parameters:
- SB_DEPTH, 3, number of in-flight destination slots tracked (EX, MEM, WB).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- inst_i  in  32  instruction from fetch; 32'h0 is a bubble.
- pc_i  in  32  PC of inst_i.
- flush_i  in  1  branch taken or jump resolved; squash the current decode.
- rs1_addr_o  out  5  combinational regfile read address (inst_i[19:15]).
- rs2_addr_o  out  5  combinational regfile read address (inst_i[24:20]).
- conflict_o  out  1  combinational RAW hazard; fetch holds inst_i.
- valid_o  out  1  registered; output bundle holds a real instruction.
- pc_o  out  32  registered PC.
- rd_o  out  5  registered destination.
- imm_o  out  32  registered sign-extended immediate.
- alu_op_o  out  4  registered ALU operation (package enum).
- funct3_o  out  3  registered funct3.
- reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, alu_src_imm_o, illegal_o  out  1 each  registered control flags.

## Operation
- Bubble: inst_i == 0. It yields valid_o=0, all flags 0, and pushes rd=0. NOP (32'h00000013) is a real instruction.
- uses_rs1 is set for all opcodes except LUI, AUIPC, JAL. uses_rs2 is set for OP, STORE, BRANCH.
- rd is recorded only when reg_we (OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR). Otherwise rd_o=0.
- conflict_o = !flush_i && !bubble && ((uses_rs1 && rs1!=0 && rs1 ∈ slot[0..SB_DEPTH-1]) || (uses_rs2 && rs2!=0 && rs2 ∈ slot[...])). There is no forwarding.
- Immediates are sign-extended from inst[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: imm_o=0.
- Unknown opcode, or a funct7 other than 0/0x20 on OP: valid_o=1, illegal_o=1, every other flag 0, rd pushed as 0.
- Scoreboard is a shift register of rd values. Each clock, slot[k] <= slot[k-1], and slot[0] <= the rd issued this cycle.
- Each clock the output register loads exactly one of the following, in priority order:
  1. flush_i: bubble (valid_o=0), slot[0] <= 0.
  2. conflict_o: bubble inserted, slot[0] <= 0. inst_i is re-presented by fetch next cycle.
  3. Otherwise: decoded bundle, slot[0] <= rd (0 if !reg_we).
- Older slots shift every cycle regardless of flush or conflict, so a stall drains in at most SB_DEPTH cycles.

## Timing
- Decode to output register latency is 1 cycle. conflict_o, rs1_addr_o and rs2_addr_o are same-cycle combinational from inst_i and the scoreboard.
- Reset (asynchronous assert, synchronous deassert via clk): every registered output is 0 and every scoreboard slot is 0.
- Reset mid-stall clears the scoreboard, so conflict_o drops immediately.
- flush_i and conflict in the same cycle: flush wins, conflict_o=0.
- An instruction that reads and writes the same register (e.g. addi x1,x1,1) does not self-conflict; only older slots are compared.
- A back-to-back dependent pair stalls SB_DEPTH cycles, then issues.

## Structure
- Package `core_pkg` holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - the `alu_op_e` enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
  - the imm format enum.
- Sub-module `imm_gen`: combinational, inst[31:0] plus format in, imm[31:0] out.
- Scoreboard and control decode stay in `decode`.

## Test plan
- Reset: assert rst_n_i=0 mid-stream -> all outputs 0 and conflict_o=0 immediately; the first post-reset addi x1,x0,5 gives valid_o=1, rd_o=1, imm_o=5 next cycle.
- RAW: addi x1,x0,1 followed by add x2,x1,x1 -> conflict_o=1 for 3 cycles, three bubbles, then add issues with rd_o=2, alu_op_o=ADD.
- x0 and non-use: addi x0,x0,0 then sw x0,0(x0) -> no conflict. lui x3 then lui x3 -> no conflict.
- Immediates:
  - beq x0,x0,-4 -> imm_o=32'hFFFFFFFC, branch_o=1.
  - jal x1,2048 -> imm_o=32'h00000800, jump_o=1.
  - sw with offset -1 -> imm_o=32'hFFFFFFFF.
- Flush: flush_i=1 during a conflicting add -> conflict_o=0, valid_o=0 next cycle, slot[0]=0.
- Illegal: inst_i=32'h0000007F -> valid_o=1, illegal_o=1, reg_we_o=0, no scoreboard entry.
